muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with early completion for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      state_o
);

    // Handshake: a request is taken on a rising edge where valid_i && ready_o;
    // ready_o is high only in IDLE, and done_o pulses for one cycle per completed op.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [6:0]        LAST    = 7'(XLEN - 1);
    localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X  = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [6:0]          cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, early;
    logic [XLEN-1:0]     early_res;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, mul_signed;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     quo, rem, div_res;
    logic                last_iter;

    assign ready_o  = (state_q == ST_IDLE);
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign state_o  = state_q;

    assign accept    = valid_i && (state_q == ST_IDLE);
    assign last_iter = (cnt_q == LAST);

    // Operand magnitudes and the sign to re-apply at the end.
    always_comb begin
        a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        a_neg    = a_signed && a_i[XLEN-1];
        b_neg    = b_signed && b_i[XLEN-1];
        a_mag    = a_neg ? (~a_i + ONE_X) : a_i;
        b_mag    = b_neg ? (~b_i + ONE_X) : b_i;
        neg_d    = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3_i[2] && (b_i == '0);
        div_ovf  = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                   (a_i == MIN_NEG) && (b_i == '1);
        early    = div_zero || div_ovf;
        if (div_zero)
            early_res = funct3_i[1] ? a_i : '1;
        else
            early_res = funct3_i[1] ? '0 : MIN_NEG;
    end

    // One multiply step: acc holds {partial high, remaining multiplier bits}.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};
        mul_signed = neg_q ? (~mul_next + ONE_2X) : mul_next;
        mul_res    = (op_q == 3'b000) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    end

    // One divide step: acc holds {remainder, dividend bits shifting into quotient}.
    always_comb begin
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        quo = div_next[XLEN-1:0];
        rem = div_next[2*XLEN-1:XLEN];
        if (op_q[1])
            div_res = neg_q ? (~rem + ONE_X) : rem;
        else
            div_res = neg_q ? (~quo + ONE_X) : quo;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (early)            state_d = ST_DONE;
                    else if (funct3_i[2]) state_d = ST_DIV;
                    else                  state_d = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush_i)        state_d = ST_IDLE;
                else if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= funct3_i;
            neg_q <= neg_d;
            cnt_q <= '0;
            if (funct3_i[2]) begin
                acc_q  <= {{XLEN{1'b0}}, a_mag};
                opnd_q <= b_mag;
            end else begin
                acc_q  <= {{XLEN{1'b0}}, b_mag};
                opnd_q <= a_mag;
            end
            if (early)
                result_q <= early_res;
        end else if (state_q == ST_MUL && !flush_i) begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 7'd1;
            if (last_iter)
                result_q <= mul_res;
        end else if (state_q == ST_DIV && !flush_i) begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 7'd1;
            if (last_iter)
                result_q <= div_res;
        end
    end

endmodule
